// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline WB stage / multi-cycle unit and the
// register-file write-port arbiter.
interface wb_port_arbiter_if;
  // Pipeline write-back stage
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        MemtoReg;
  logic        jal_wr;
  logic [31:0] Result;
  logic [31:0] Memread;
  logic [31:0] link_addr;
  // Multi-cycle unit offer
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  // Register-file write port and status
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        mc_pending;

  // Arbiter side
  modport slave (
    input  wb_valid, wb_rd, MemtoReg, jal_wr, Result, Memread, link_addr,
    input  mc_valid, mc_rd, mc_data,
    output mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, mc_pending
  );

  // Producer / observer side
  modport master (
    output wb_valid, wb_rd, MemtoReg, jal_wr, Result, Memread, link_addr,
    output mc_valid, mc_rd, mc_data,
    input  mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, mc_pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline WB stage and a
// multi-cycle unit. Pipeline has priority; mc results wait in a 2-entry FIFO
// and a starvation counter asks the hazard unit for a WB bubble.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  wb_port_arbiter_if.slave   bus
);

  localparam int unsigned StarveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [4:0]         eff_rd;
  logic [31:0]        eff_data;
  logic               pipe_grant, mc_xfer, mc_live, pop, bypass, push, wr_idx;

  logic [1:0]         count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [4:0]         fifo_rd_q [2];
  logic [4:0]         fifo_rd_d [2];
  logic [31:0]        fifo_data_q [2];
  logic [31:0]        fifo_data_d [2];
  logic [StarveW-1:0] starve_q, starve_d;
  logic               stall_req_q, stall_req_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [31:0]        rf_wdata_q, rf_wdata_d;

  // Effective pipeline write and per-cycle ownership decision
  always_comb begin
    eff_rd     = bus.jal_wr ? 5'd31 : bus.wb_rd;
    eff_data   = bus.jal_wr ? bus.link_addr : (bus.MemtoReg ? bus.Memread : bus.Result);
    pipe_grant = bus.wb_valid && (eff_rd != 5'd0);
    mc_xfer    = bus.mc_valid && (count_q != 2'd2);
    // rd=0 results are accepted but never written or buffered
    mc_live    = mc_xfer && (bus.mc_rd != 5'd0);
    pop        = !pipe_grant && (count_q != 2'd0);
    bypass     = !pipe_grant && (count_q == 2'd0) && mc_live;
    push       = mc_live && !bypass;
    wr_idx     = rd_ptr_q ^ count_q[0];
  end

  // Next-state for write port, FIFO and starvation tracking
  always_comb begin
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;

    if (pipe_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = eff_rd;
      rf_wdata_d = eff_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.mc_rd;
      rf_wdata_d = bus.mc_data;
    end

    // Tail slot is computed from the pre-pop count, so push+pop at count=1
    // lands the new entry in the slot that becomes the head.
    if (push) begin
      fifo_rd_d[wr_idx]   = bus.mc_rd;
      fifo_data_d[wr_idx] = bus.mc_data;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if ((count_q != 2'd0) && pipe_grant) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1);
    end else begin
      starve_d = '0;
    end
    stall_req_d = (starve_q == StarveMax) && !pop;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      count_q     <= '0;
      rd_ptr_q    <= 1'b0;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      starve_q    <= starve_d;
      stall_req_q <= stall_req_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign bus.mc_ready   = (count_q != 2'd2);
  assign bus.mc_pending = (count_q != 2'd0);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.stall_req  = stall_req_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, consecutive blocked cycles before stall_req is raised.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 wb_valid  input  1  pipeline WB stage holds a register write this cycle.
REQ-005 wb_rd  input  5  pipeline destination register.
REQ-006 MemtoReg  input  1  select Memread (1) or Result (0) for pipeline data.
REQ-007 jal_wr  input  1  pipeline write is a link write; overrides MemtoReg and wb_rd.
REQ-008 Result  input  32  ALU result from pipeline.
REQ-009 Memread  input  32  load data from pipeline.
REQ-010 link_addr  input  32  return address for jal/jalr.
REQ-011 mc_valid  input  1  multi-cycle unit (mul/div) offers a result.
REQ-012 mc_rd  input  5  multi-cycle destination register.
REQ-013 mc_data  input  32  multi-cycle result.
REQ-014 mc_ready  output  1  block accepts mc result this cycle.
REQ-015 rf_we  output  1  register file write enable (registered).
REQ-016 rf_waddr  output  5  register file write address (registered).
REQ-017 rf_wdata  output  32  register file write data (registered).
REQ-018 stall_req  output  1  request to hazard unit to insert a WB bubble (registered).
REQ-019 mc_pending  output  1  buffered mc results exist (count != 0).

Function
REQ-020 Pipeline data SHALL be link_addr with address 31 when jal_wr=1, else Memread when MemtoReg=1, else Result, with address wb_rd.
REQ-021 Block SHALL hold a 2-entry FIFO (addr+data) for mc results; mc_ready SHALL equal (count < 2) from registered count, independent of same-cycle pop.
REQ-022 mc handshake: transfer occurs when mc_valid=1 and mc_ready=1; mc_valid without mc_ready SHALL leave the offer unconsumed.
REQ-023 Port owner per cycle, priority order: (a) pipeline if wb_valid=1 and effective rd != 0; (b) FIFO head if count>0; (c) incoming mc transfer bypass if count==0; else idle.
REQ-024 The granted write SHALL appear on rf_we/rf_waddr/rf_wdata at the next rising edge (latency 1); idle cycle SHALL yield rf_we=0, rf_waddr/rf_wdata unchanged.
REQ-025 Pipeline write with effective rd=0 SHALL produce no rf_we and SHALL leave the port free for (b)/(c) that cycle.
REQ-026 mc transfer with mc_rd=0 SHALL be accepted and discarded (no enqueue, no write).
REQ-027 mc transfer not bypassed and not discarded SHALL enqueue at FIFO tail; FIFO SHALL preserve arrival order.
REQ-028 Simultaneous pop and push at count=1 SHALL leave count=1 with new entry at head after the old head is written.
REQ-029 Starvation counter SHALL increment (saturating at STARVE_LIMIT) each cycle with count>0 and pipeline owning the port; SHALL clear on any FIFO pop or when count==0.
REQ-030 stall_req SHALL be 1 in the cycle after the counter equals STARVE_LIMIT and SHALL drop the cycle after a pop; block does not itself suppress wb_valid.
REQ-031 WAW ordering between pipeline and mc writes is the issue scoreboard's responsibility; block SHALL not reorder or kill entries.

Reset
REQ-032 While rst_n=0 (asynchronously): rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, FIFO count=0, starvation counter=0; consequently mc_pending=0, mc_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all buffered mc results; first edge after release SHALL behave as empty state.

Verification
REQ-034 wb_valid=1, MemtoReg=1, wb_rd=5, Memread=0xDEADBEEF -> next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-035 wb_valid=1, jal_wr=1, wb_rd=7, link_addr=0x100 -> rf_waddr=31, rf_wdata=0x100.
REQ-036 wb_valid=0, count=0, mc transfer rd=3 data=0x2A -> next edge rf_waddr=3, rf_wdata=0x2A, mc_pending stays 0.
REQ-037 wb_valid=1 continuous, three mc offers rd=1,2,3 -> first two accepted, mc_ready=0 at count=2, stall_req=1 after 4 blocked cycles; drop wb_valid -> writes rd=1 then rd=2, stall_req clears, rd=3 accepted.
REQ-038 Pipeline wb_rd=0 while count=1 head rd=9 -> next edge rf_we=1, rf_waddr=9 (head drains).
REQ-039 count=2, assert rst_n=0 for one cycle -> rf_we=0, mc_pending=0, mc_ready=1 immediately; no buffered write ever appears.
